// File: rtl/mpc_dot_acc.sv
// mpc_dot_acc: accumulates a run of signed products. The sum is then rounded,
// shifted and saturated into a single OUT_W-bit result that is pulsed out.
module mpc_dot_acc #(
  parameter int IN_W  = 36,
  parameter int ACC_W = 48,
  parameter int OUT_W = 21,
  parameter int SHIFT = 14,
  parameter int LEN_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  // The accumulator must absorb 2^LEN_W-1 full-scale terms without wrapping.
  if (ACC_W < IN_W + LEN_W) begin : g_acc_w_chk
    $error("mpc_dot_acc: ACC_W must be >= IN_W + LEN_W");
  end
  if (SHIFT < 1) begin : g_shift_chk
    $error("mpc_dot_acc: SHIFT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_t;

  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT-1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                   state, state_nx;
  logic signed [ACC_W-1:0]  acc, acc_nx;
  logic [LEN_W-1:0]         cnt, cnt_nx;
  logic                     busy_nx;
  logic                     out_valid_nx;
  logic signed [OUT_W-1:0]  out_data_nx;
  logic                     out_sat_nx;

  logic signed [ACC_W-1:0]  term_ext;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    rnd_res;

  assign term_ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  // One extra bit keeps the rounding offset from overflowing a full-scale acc.
  assign rnd_sum  = {acc[ACC_W-1], acc} + HALF;
  assign rnd_res  = rnd_sum >>> SHIFT;

  // Next-state, datapath update and output formatting.
  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    cnt_nx       = cnt;
    out_valid_nx = 1'b0;
    out_data_nx  = out_data;
    out_sat_nx   = out_sat;
    case (state)
      S_IDLE: begin
        if (start) begin
          acc_nx = '0;
          if (len != '0) begin
            cnt_nx   = len;
            state_nx = S_ACC;
          end else begin
            state_nx = S_OUT;
          end
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_nx = acc + term_ext;
          cnt_nx = cnt - 1'b1;
          if (cnt == LEN_W'(1)) state_nx = S_OUT;
        end
      end
      S_OUT: begin
        out_valid_nx = 1'b1;
        if (rnd_res > MAXV) begin
          out_data_nx = MAXV[OUT_W-1:0];
          out_sat_nx  = 1'b1;
        end else if (rnd_res < MINV) begin
          out_data_nx = MINV[OUT_W-1:0];
          out_sat_nx  = 1'b1;
        end else begin
          out_data_nx = rnd_res[OUT_W-1:0];
          out_sat_nx  = 1'b0;
        end
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  // State and output registers; everything holds while ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (ce) begin
      state     <= state_nx;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      busy      <= busy_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      out_sat   <= out_sat_nx;
    end
  end

endmodule

// File: tb/tb_mpc_dot_acc.sv
// tb_mpc_dot_acc: directed scenarios for mpc_dot_acc at default parameters.
module tb_mpc_dot_acc;

  logic               clk;
  logic               rst_n;
  logic               ce;
  logic               start;
  logic [5:0]         len;
  logic               in_valid;
  logic signed [35:0] in_data;
  logic               busy;
  logic               out_valid;
  logic signed [20:0] out_data;
  logic               out_sat;

  int n_cmp;
  int n_fail;

  mpc_dot_acc #(
    .IN_W (36),
    .ACC_W(48),
    .OUT_W(21),
    .SHIFT(14),
    .LEN_W(6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .busy     (busy),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation of up to three back-to-back terms and reports the
  // result, the edges from last accept to out_valid, and out_valid one edge later.
  task automatic do_op(input int n, input logic signed [35:0] t0, input logic signed [35:0] t1,
                       input logic signed [35:0] t2, output logic signed [20:0] od,
                       output logic os, output int lat, output logic ov_after);
    start = 1'b1;
    len   = 6'(n);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? t0 : (i == 1) ? t1 : t2;
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    od = out_data;
    os = out_sat;
    step();
    ov_after = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp += 4;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_data !== 21'sd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic signed [20:0] od; logic os; int lat; logic ova;
    // 16384 + 32768 - 16384 = 32768; (32768 + 8192) >>> 14 = 2
    do_op(3, 36'sd16384, 36'sd32768, -36'sd16384, od, os, lat, ova);
    n_cmp += 4;
    if (od !== 21'sd2) begin n_fail++; $display("FAIL basic_data: got %0d want 2", od); end
    if (os !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b want 0", os); end
    if (lat != 1) begin n_fail++; $display("FAIL basic_latency: got %0d want 1", lat); end
    if (ova !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: out_valid got %b want 0", ova); end
  endtask

  task automatic test_rounding();
    logic signed [35:0] vin [4];
    logic signed [20:0] vexp [4];
    logic signed [20:0] od; logic os; int lat; logic ova;
    vin[0] = 36'sd8192;  vexp[0] = 21'sd1;
    vin[1] = -36'sd8192; vexp[1] = 21'sd0;
    vin[2] = -36'sd8193; vexp[2] = -21'sd1;
    vin[3] = 36'sd24575; vexp[3] = 21'sd1;
    for (int i = 0; i < 4; i++) begin
      do_op(1, vin[i], '0, '0, od, os, lat, ova);
      n_cmp += 2;
      if (od !== vexp[i]) begin n_fail++; $display("FAIL round_%0d: got %0d want %0d", i, od, vexp[i]); end
      if (os !== 1'b0) begin n_fail++; $display("FAIL round_sat_%0d: got %b want 0", i, os); end
    end
  endtask

  task automatic test_saturation();
    logic signed [35:0] vin [6];
    int                 vn [6];
    logic signed [20:0] vexp [6];
    logic               vsat [6];
    logic signed [20:0] od; logic os; int lat; logic ova;
    vin[0] = 36'sh7_FFFF_FFFF;     vn[0] = 2; vexp[0] = 21'sd1048575;  vsat[0] = 1'b1;
    vin[1] = -36'sh8_0000_0000;    vn[1] = 2; vexp[1] = -21'sd1048576; vsat[1] = 1'b1;
    vin[2] = 36'sd17179852800;     vn[2] = 1; vexp[2] = 21'sd1048575;  vsat[2] = 1'b0;
    vin[3] = 36'sd17179860992;     vn[3] = 1; vexp[3] = 21'sd1048575;  vsat[3] = 1'b1;
    vin[4] = -36'sd17179869184;    vn[4] = 1; vexp[4] = -21'sd1048576; vsat[4] = 1'b0;
    vin[5] = -36'sd17179877377;    vn[5] = 1; vexp[5] = -21'sd1048576; vsat[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_op(vn[i], vin[i], vin[i], '0, od, os, lat, ova);
      n_cmp += 2;
      if (od !== vexp[i]) begin n_fail++; $display("FAIL sat_data_%0d: got %0d want %0d", i, od, vexp[i]); end
      if (os !== vsat[i]) begin n_fail++; $display("FAIL sat_flag_%0d: got %b want %b", i, os, vsat[i]); end
    end
  endtask

  task automatic test_stalls();
    int lat;
    start = 1'b1; len = 6'd2;
    step();
    start = 1'b0;
    step();                                   // in_valid gap
    in_valid = 1'b1; in_data = 36'sd16384;
    step();
    ce = 1'b0; in_data = 36'sd999999;         // ignored while ce is low
    for (int i = 0; i < 3; i++) step();
    n_cmp += 1;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b want 1", busy); end
    ce = 1'b1; in_valid = 1'b0;
    step();                                   // another gap
    in_valid = 1'b1; in_data = 36'sd16384;
    step();                                   // last accept
    in_valid = 1'b0; in_data = '0;
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp += 1;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_early_valid_%0d: got %b want 0", i, out_valid); end
    end
    ce = 1'b1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    n_cmp += 3;
    if (lat != 1) begin n_fail++; $display("FAIL stall_latency: got %0d want 1 after ce resumes", lat); end
    if (out_data !== 21'sd2) begin n_fail++; $display("FAIL stall_data: got %0d want 2", out_data); end
    if (out_sat !== 1'b0) begin n_fail++; $display("FAIL stall_sat: got %b want 0", out_sat); end
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp += 1;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid_%0d: got %b want 1", i, out_valid); end
    end
    ce = 1'b1;
    step();
    n_cmp += 1;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_clear: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midop();
    logic signed [20:0] od; logic os; int lat; logic ova;
    logic seen;
    start = 1'b1; len = 6'd3;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 36'sd16384;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 1;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_busy_drop: got %b want 0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); if (out_valid === 1'b1) seen = 1'b1; end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); if (out_valid === 1'b1) seen = 1'b1; end
    n_cmp += 1;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midop_no_valid: got %b want 0", seen); end
    do_op(1, 36'sd16384, '0, '0, od, os, lat, ova);
    n_cmp += 2;
    if (od !== 21'sd1) begin n_fail++; $display("FAIL midop_restart_data: got %0d want 1", od); end
    if (lat != 1) begin n_fail++; $display("FAIL midop_restart_latency: got %0d want 1", lat); end
  endtask

  task automatic test_len0_and_busy_start();
    logic signed [20:0] od; logic os; int lat; logic ova;
    do_op(0, '0, '0, '0, od, os, lat, ova);
    n_cmp += 3;
    if (od !== 21'sd0) begin n_fail++; $display("FAIL len0_data: got %0d want 0", od); end
    if (os !== 1'b0) begin n_fail++; $display("FAIL len0_sat: got %b want 0", os); end
    if (lat != 1) begin n_fail++; $display("FAIL len0_latency: got %0d want 1", lat); end
    // start held high with a different len for the whole operation
    start = 1'b1; len = 6'd2;
    step();
    len = 6'd1;
    n_cmp += 1;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
    in_valid = 1'b1; in_data = 36'sd16384;
    step();
    in_data = 36'sd16384;
    step();
    in_valid = 1'b0; in_data = '0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    start = 1'b0;
    n_cmp += 3;
    if (lat != 1) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 1", lat); end
    if (out_data !== 21'sd2) begin n_fail++; $display("FAIL busy_start_data: got %0d want 2", out_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got %b want 0", busy); end
    step();
    step();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; ce = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_stalls();
    test_reset_midop();
    test_len0_and_busy_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
